// File: rtl/mem_arbiter.sv
// Two-requester (CPU / host) single-port memory arbiter.
// Each transaction runs IDLE -> ACCESS (WAIT_CYCLES cycles) -> DONE.
// ACCESS drives the memory bus. DONE returns a one-cycle ack.
// Optional feature macro: ARB_ROUND_ROBIN_EN.
//   Defined:   ties alternate between the two requesters.
//   Undefined: the CPU always wins a tie.
module mem_arbiter #(
  parameter int unsigned WAIT_CYCLES = 1
) (
  input  logic       clk_i,
  input  logic       rst_ni,
  input  logic       cpu_rd_i,
  input  logic       cpu_wr_i,
  input  logic [4:0] cpu_addr_i,
  input  logic [7:0] cpu_wdata_i,
  output logic [7:0] cpu_rdata_o,
  output logic       cpu_ack_o,
  input  logic       host_rd_i,
  input  logic       host_wr_i,
  input  logic [4:0] host_addr_i,
  input  logic [7:0] host_wdata_i,
  output logic [7:0] host_rdata_o,
  output logic       host_ack_o,
  output logic       mem_en_o,
  output logic       mem_we_o,
  output logic [4:0] mem_addr_o,
  output logic [7:0] mem_wdata_o,
  input  logic [7:0] mem_rdata_i,
  output logic       busy_o
);

  typedef enum logic [1:0] {StIdle, StAccess, StDone} state_e;

  state_e     state_q;
  logic [3:0] cnt_q;
  logic       gnt_host_q;
  logic       mem_en_q, mem_we_q;
  logic [4:0] mem_addr_q;
  logic [7:0] mem_wdata_q;
  logic [7:0] cpu_rdata_q, host_rdata_q;
  logic       cpu_ack_q, host_ack_q;

  logic       cpu_req, host_req, grant_host;
  logic       sel_we;
  logic [4:0] sel_addr;
  logic [7:0] sel_wdata;

  assign cpu_req  = cpu_rd_i | cpu_wr_i;
  assign host_req = host_rd_i | host_wr_i;

`ifdef ARB_ROUND_ROBIN_EN
  // Last-grant register: 1 = host. The reset value makes the CPU win the first tie.
  logic last_host_q;

  // On a tie, grant the requester that was not granted last.
  always_comb begin
    grant_host = host_req & (~cpu_req | ~last_host_q);
  end

  // Update the last-grant register on every grant.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      last_host_q <= 1'b1;
    end else if (state_q == StIdle && (cpu_req || host_req)) begin
      last_host_q <= grant_host;
    end
  end
`else
  // Fixed priority: the CPU wins every tie.
  always_comb begin
    grant_host = host_req & ~cpu_req;
  end
`endif

  // Select the granted requester's operation.
  // A write wins over a read from the same requester.
  always_comb begin
    sel_we    = grant_host ? host_wr_i    : cpu_wr_i;
    sel_addr  = grant_host ? host_addr_i  : cpu_addr_i;
    sel_wdata = grant_host ? host_wdata_i : cpu_wdata_i;
  end

  // Main FSM. All outputs are registered here.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q      <= StIdle;
      cnt_q        <= 4'd0;
      gnt_host_q   <= 1'b0;
      mem_en_q     <= 1'b0;
      mem_we_q     <= 1'b0;
      mem_addr_q   <= 5'd0;
      mem_wdata_q  <= 8'd0;
      cpu_rdata_q  <= 8'd0;
      host_rdata_q <= 8'd0;
      cpu_ack_q    <= 1'b0;
      host_ack_q   <= 1'b0;
    end else begin
      case (state_q)
        StIdle: begin
          if (cpu_req || host_req) begin
            state_q     <= StAccess;
            gnt_host_q  <= grant_host;
            cnt_q       <= 4'(WAIT_CYCLES);
            mem_en_q    <= 1'b1;
            mem_we_q    <= sel_we;
            mem_addr_q  <= sel_addr;
            mem_wdata_q <= sel_wdata;
          end
        end
        StAccess: begin
          cnt_q <= cnt_q - 4'd1;
          if (cnt_q == 4'd1) begin
            state_q  <= StDone;
            mem_en_q <= 1'b0;
            mem_we_q <= 1'b0;
            // Read data is valid on the last ACCESS edge.
            if (!mem_we_q) begin
              if (gnt_host_q) host_rdata_q <= mem_rdata_i;
              else            cpu_rdata_q  <= mem_rdata_i;
            end
            if (gnt_host_q) host_ack_q <= 1'b1;
            else            cpu_ack_q  <= 1'b1;
          end
        end
        StDone: begin
          cpu_ack_q  <= 1'b0;
          host_ack_q <= 1'b0;
          state_q    <= StIdle;
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  assign cpu_rdata_o  = cpu_rdata_q;
  assign host_rdata_o = host_rdata_q;
  assign cpu_ack_o    = cpu_ack_q;
  assign host_ack_o   = host_ack_q;
  assign mem_en_o     = mem_en_q;
  assign mem_we_o     = mem_we_q;
  assign mem_addr_o   = mem_addr_q;
  assign mem_wdata_o  = mem_wdata_q;
  assign busy_o       = (state_q != StIdle);

endmodule
